fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the RISC-V core. It owns the program counter and drives the address and write port of the 64-word instruction memory. It registers the fetched word into the IF/ID pipeline register for the decoder. It also provides a streaming program-load mode that writes a new program into instruction memory through that memory's write port.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and after a program load completes
IMEM_WORDS, 64, instruction-memory depth in 32-bit words; load address limit is IMEM_WORDS*4
NOP_INSTR, 32'h0000_0013, word presented on ifid_instr when the IF/ID register holds a bubble

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard stall from decode; hold PC and IF/ID
flush  in  1  squash the instruction held in IF/ID
redirect_valid  in  1  branch/jump taken, resolved downstream
redirect_pc  in  32  redirect target
load_start  in  1  enter program-load mode
load_valid  in  1  load word valid
load_data  in  32  load word
load_last  in  1  marks the final load word
load_ready  out  1  fetch stage accepts a load word this cycle
imem_pc  out  32  address to instruction memory
imem_write_en  out  1  instruction-memory write enable
imem_write_instr  out  32  instruction-memory write data
imem_instr  in  32  combinational read data from instruction memory
ifid_valid  out  1  IF/ID holds a real instruction
ifid_pc  out  32  PC of the IF/ID instruction
ifid_pc_plus4  out  32  ifid_pc + 4
ifid_instr  out  32  fetched instruction, or NOP_INSTR when ifid_valid=0
load_overflow  out  1  sticky: a load word arrived beyond IMEM_WORDS
busy_loading  out  1  state == LOAD

Behaviour:
- Reset (clk edge with reset=1): state=RUN, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_instr=NOP_INSTR, load_overflow=0, imem_write_en=0, load_ready=0.
- Instruction memory reloads its own contents during the same reset. The first fetch is valid on the cycle after reset deasserts.
- imem_pc = pc register in every state. imem_write_instr = load_data. imem_write_en = (state==LOAD) && load_valid && address in range.
- States and transitions:
  - RUN -> LOAD on load_start.
  - LOAD -> RUN on an accepted beat with load_last=1.
- RUN, normal cycle: IF/ID <= {valid=1, pc, pc+4, imem_instr}; pc <= pc+4. Fetch latency is 1 cycle; pc wraps modulo 2^32.
- RUN priority, highest first: load_start > redirect_valid > flush > stall > normal.
  - redirect_valid: pc <= {redirect_pc[31:2],2'b00}; ifid_valid <= 0. This applies even when stall=1; redirect overrides stall.
  - flush without redirect: ifid_valid <= 0; pc advances unless stall=1.
  - stall only: pc and all IF/ID fields hold.
- load_start in RUN: pc <= 0; ifid_valid <= 0; load_overflow <= 0. Any simultaneous redirect is ignored.
- LOAD:
  - load_ready=1 every cycle.
  - Beat accepted when load_valid=1. If pc < IMEM_WORDS*4, the word is written at mem[pc[31:2]] on that edge; otherwise it is discarded and load_overflow <= 1.
  - pc <= pc+4 per accepted beat.
  - stall, flush, redirect and load_start are ignored. ifid_valid stays 0.
  - Accepted beat with load_last=1: state <= RUN, pc <= RESET_PC. Fetch resumes the next cycle.
- load_last with load_valid=0 is ignored.
- Reset mid-load returns to RUN at RESET_PC. Instruction memory's reset image replaces any partially loaded words.

Optional Feature:
FETCH_BOUNDS_CHECK_EN
- Defined: in RUN, if pc >= IMEM_WORDS*4, IF/ID captures valid=1 with instr=NOP_INSTR instead of imem_instr. A sticky output fetch_oob (1 bit, reset 0) is added and set.
- Not defined: no check is made; imem_instr is passed through as read, and the port fetch_oob does not exist.

Test Plan:
- Reset, then 4 free-running cycles -> ifid_pc sequence 0x0, 0x4, 0x8, 0xC with ifid_instr 0x00000000, 0x00500113, 0x00C00193, 0xFF718393; ifid_valid=0 on the first cycle after reset.
- Redirect_valid=1 with redirect_pc=0x2A while stall=1 -> next imem_pc=0x28; ifid_valid=0 next cycle; the following cycle ifid_pc=0x28.
- Stall held 3 cycles at pc=0x10 -> imem_pc stays 0x10 and ifid_* unchanged; flush during the stall -> ifid_valid=0 and pc still 0x10.
- load_start, then 3 beats 0x00100093, 0x00200113, 0x002081B3 (last on the third), with load_valid gapped -> imem_write_en pulses at pc 0x0, 0x4, 0x8 only; next RUN fetch gives ifid_instr=0x00100093 at ifid_pc=0x0.
- Load of 66 beats -> words 64 and 65 are discarded with imem_write_en=0, and load_overflow=1 until the next load_start or reset.
- Reset asserted on the 2nd load beat -> state=RUN, pc=0, busy_loading=0; the reset-image instruction 0x00500113 appears at ifid_pc=0x4.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V instruction fetch stage with PC, IF/ID register and streaming program load.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (adds sticky fetch_oob and NOP substitution past IMEM).
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic [31:0] imem_pc,
  output logic        imem_write_en,
  output logic [31:0] imem_write_instr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        load_overflow,
  output logic        busy_loading
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic        fetch_oob
`endif
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);

  typedef enum logic {S_RUN, S_LOAD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        load_overflow_q, load_overflow_d;

  logic        pc_in_range;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_word;

  assign pc_in_range = (pc_q < IMEM_BYTES);
  assign pc_plus4    = pc_q + 32'd4;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fetch_oob_q, fetch_oob_d;
  assign fetch_word = pc_in_range ? imem_instr : NOP_INSTR;
  assign fetch_oob  = fetch_oob_q;
`else
  assign fetch_word = imem_instr;
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    load_overflow_d = load_overflow_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fetch_oob_d     = fetch_oob_q;
`endif
    if (state_q == S_RUN) begin
      if (load_start) begin
        state_d         = S_LOAD;
        pc_d            = 32'd0;
        ifid_valid_d    = 1'b0;
        load_overflow_d = 1'b0;
      end else if (redirect_valid) begin
        // Redirect wins over stall: the stalled instruction is on the wrong path anyway.
        pc_d         = redirect_pc & ~32'd3;
        ifid_valid_d = 1'b0;
      end else if (flush) begin
        ifid_valid_d = 1'b0;
        if (!stall) begin
          pc_d = pc_plus4;
        end
      end else if (!stall) begin
        ifid_valid_d    = 1'b1;
        ifid_pc_d       = pc_q;
        ifid_pc_plus4_d = pc_plus4;
        ifid_instr_d    = fetch_word;
        pc_d            = pc_plus4;
`ifdef FETCH_BOUNDS_CHECK_EN
        if (!pc_in_range) begin
          fetch_oob_d = 1'b1;
        end
`endif
      end
    end else begin
      if (load_valid) begin
        if (!pc_in_range) begin
          load_overflow_d = 1'b1;
        end
        if (load_last) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_RUN;
      pc_q            <= RESET_PC;
      ifid_valid_q    <= 1'b0;
      ifid_pc_q       <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_instr_q    <= NOP_INSTR;
      load_overflow_q <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_oob_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      load_overflow_q <= load_overflow_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_oob_q     <= fetch_oob_d;
`endif
    end
  end

  assign load_ready       = (state_q == S_LOAD);
  assign busy_loading     = (state_q == S_LOAD);
  assign imem_pc          = pc_q;
  assign imem_write_instr = load_data;
  assign imem_write_en    = (state_q == S_LOAD) && load_valid && pc_in_range;
  assign ifid_valid       = ifid_valid_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_pc_plus4    = ifid_pc_plus4_q;
  assign ifid_instr       = ifid_valid_q ? ifid_instr_q : NOP_INSTR;
  assign load_overflow    = load_overflow_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: vector table, load sequences, random vs reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset, stall, flush, redirect_valid, load_start, load_valid, load_last;
  logic [31:0] redirect_pc, load_data;
  logic        load_ready, imem_write_en, ifid_valid, load_overflow, busy_loading;
  logic [31:0] imem_pc, imem_write_instr, imem_instr, ifid_pc, ifid_pc_plus4, ifid_instr;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fetch_oob;
`endif

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .imem_pc(imem_pc),
    .imem_write_en(imem_write_en), .imem_write_instr(imem_write_instr),
    .imem_instr(imem_instr), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .load_overflow(load_overflow), .busy_loading(busy_loading)
`ifdef FETCH_BOUNDS_CHECK_EN
    , .fetch_oob(fetch_oob)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] img(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h0050_0113;
      2:       return 32'h00C0_0193;
      3:       return 32'hFF71_8393;
      default: return 32'hA000_0000 + 32'(i);
    endcase
  endfunction

  // Instruction memory: reloads its image on reset, written through the DUT's write port.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= img(i);
    end else if (imem_write_en) begin
      mem[imem_pc[7:2]] <= imem_write_instr;
    end
  end
  assign imem_instr = mem[imem_pc[7:2]];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural view (mode, pc, IF/ID contents, memory image).
  bit          m_load;
  logic [31:0] m_pc, m_ipc, m_instr;
  bit          m_v, m_ovf;
  logic [31:0] mm [64];

  task automatic model_step();
    if (reset) begin
      m_load = 0; m_pc = 0; m_v = 0; m_ipc = 0; m_instr = NOP; m_ovf = 0;
      for (int i = 0; i < 64; i++) mm[i] = img(i);
    end else if (m_load) begin
      if (load_valid) begin
        if (m_pc < 32'd256) mm[m_pc[7:2]] = load_data;
        else m_ovf = 1;
        if (load_last) begin m_load = 0; m_pc = 0; end
        else m_pc = m_pc + 4;
      end
    end else if (load_start) begin
      m_load = 1; m_pc = 0; m_v = 0; m_ovf = 0;
    end else if (redirect_valid) begin
      m_pc = (redirect_pc >> 2) << 2; m_v = 0;
    end else if (flush) begin
      m_v = 0;
      if (!stall) m_pc = m_pc + 4;
    end else if (!stall) begin
      m_v = 1; m_ipc = m_pc; m_instr = mm[m_pc[7:2]]; m_pc = m_pc + 4;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
  endtask

  typedef struct {
    logic        stall, flush, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, einstr, eimem;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                              input logic [31:0] eim);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.einstr = ei; v.eimem = eim;
    return v;
  endfunction

  vec_t vecs[16];
  logic [31:0] ld_words[3];
  logic [31:0] exp_pc;
  int beat;
  bit exp_we;

  initial begin
    vecs[0]  = mk(0, 0, 0, 0,            1, 32'h0,        32'h0000_0000, 32'h4);
    vecs[1]  = mk(0, 0, 0, 0,            1, 32'h4,        32'h0050_0113, 32'h8);
    vecs[2]  = mk(0, 0, 0, 0,            1, 32'h8,        32'h00C0_0193, 32'hC);
    vecs[3]  = mk(0, 0, 0, 0,            1, 32'hC,        32'hFF71_8393, 32'h10);
    vecs[4]  = mk(1, 0, 0, 0,            1, 32'hC,        32'hFF71_8393, 32'h10);
    vecs[5]  = mk(1, 0, 0, 0,            1, 32'hC,        32'hFF71_8393, 32'h10);
    vecs[6]  = mk(1, 1, 0, 0,            0, 0,            NOP,           32'h10);
    vecs[7]  = mk(1, 0, 0, 0,            0, 0,            NOP,           32'h10);
    vecs[8]  = mk(0, 0, 0, 0,            1, 32'h10,       32'hA000_0004, 32'h14);
    vecs[9]  = mk(1, 0, 1, 32'h2A,       0, 0,            NOP,           32'h28);
    vecs[10] = mk(0, 0, 0, 0,            1, 32'h28,       32'hA000_000A, 32'h2C);
    vecs[11] = mk(0, 1, 0, 0,            0, 0,            NOP,           32'h30);
    vecs[12] = mk(0, 0, 0, 0,            1, 32'h30,       32'hA000_000C, 32'h34);
    vecs[13] = mk(1, 1, 1, 32'hFFFF_FFFF, 0, 0,            NOP,           32'hFFFF_FFFC);
    vecs[14] = mk(0, 0, 0, 0,            1, 32'hFFFF_FFFC, 32'hA000_003F, 32'h0);
    vecs[15] = mk(0, 0, 0, 0,            1, 32'h0,        32'h0000_0000, 32'h4);
    ld_words[0] = 32'h0010_0093; ld_words[1] = 32'h0020_0113; ld_words[2] = 32'h0020_81B3;

    // Reset state
    idle(); reset = 1;
    tick();
    reset = 0;
    chk("rst_valid", ifid_valid, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_pc4", ifid_pc_plus4, 0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_imem_pc", imem_pc, 0);
    chk("rst_we", imem_write_en, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_ovf", load_overflow, 0);
    chk("rst_busy", busy_loading, 0);

    // Vector table: free-run, stall, flush, redirect, pc wrap
    for (int i = 0; i < 16; i++) begin
      idle();
      stall = vecs[i].stall; flush = vecs[i].flush;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      tick();
      chk($sformatf("v%0d_valid", i), ifid_valid, vecs[i].ev);
      chk($sformatf("v%0d_instr", i), ifid_instr, vecs[i].einstr);
      chk($sformatf("v%0d_imem_pc", i), imem_pc, vecs[i].eimem);
      if (vecs[i].ev) begin
        chk($sformatf("v%0d_pc", i), ifid_pc, vecs[i].epc);
        chk($sformatf("v%0d_pc4", i), ifid_pc_plus4, vecs[i].epc + 32'd4);
      end
    end

    // Three-beat gapped load; redirect/stall/flush and a stray load_last are ignored
    idle(); load_start = 1; redirect_valid = 1; redirect_pc = 32'h80;
    tick();
    chk("ld_busy", busy_loading, 1);
    chk("ld_ready", load_ready, 1);
    chk("ld_start_pc", imem_pc, 0);
    chk("ld_start_valid", ifid_valid, 0);
    beat = 0; exp_pc = 0;
    for (int c = 0; c < 6; c++) begin
      idle(); stall = 1; flush = 1; redirect_valid = 1; redirect_pc = 32'h40;
      load_valid = c[0];
      load_last = (c == 0) || (beat == 2 && c[0]);
      load_data = c[0] ? ld_words[beat] : 32'hDEAD_BEEF;
      #1;
      chk($sformatf("ld3_we%0d", c), imem_write_en, 32'(c[0]));
      chk($sformatf("ld3_pc%0d", c), imem_pc, exp_pc);
      chk($sformatf("ld3_ready%0d", c), load_ready, 1);
      tick();
      chk($sformatf("ld3_valid%0d", c), ifid_valid, 0);
      if (c[0]) begin beat++; exp_pc = exp_pc + 4; end
    end
    idle();
    chk("ld3_done_busy", busy_loading, 0);
    chk("ld3_done_pc", imem_pc, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ld3_fetch_pc%0d", k), ifid_pc, 32'(k * 4));
      chk($sformatf("ld3_fetch_instr%0d", k), ifid_instr, ld_words[k]);
    end

    // 66-beat load: last two beats overflow
    idle(); load_start = 1;
    tick();
    for (int b = 0; b < 66; b++) begin
      idle(); load_valid = 1; load_data = 32'h0BAD_0000 + 32'(b); load_last = (b == 65);
      #1;
      chk($sformatf("ld66_we%0d", b), imem_write_en, 32'(b < 64));
      chk($sformatf("ld66_pc%0d", b), imem_pc, 32'(b * 4));
      tick();
      if (b == 63) chk("ld66_ovf_before", load_overflow, 0);
      if (b == 64) chk("ld66_ovf_set", load_overflow, 1);
    end
    idle();
    chk("ld66_busy", busy_loading, 0);
    tick(); tick();
    chk("ld66_ovf_sticky", load_overflow, 1);
    chk("ld66_word1", ifid_instr, 32'h0BAD_0001);
    load_start = 1;
    tick();
    chk("ld66_ovf_clear", load_overflow, 0);
    idle(); load_valid = 1; load_last = 1; load_data = 32'h0000_0013;
    tick();
    idle();

    // Reset on the second beat of a load
    load_start = 1;
    tick();
    idle(); load_valid = 1; load_data = 32'h1234_5678;
    tick();
    load_data = 32'h8765_4321; reset = 1;
    tick();
    idle();
    chk("rml_busy", busy_loading, 0);
    chk("rml_pc", imem_pc, 0);
    chk("rml_valid", ifid_valid, 0);
    tick();
    chk("rml_instr0", ifid_instr, 32'h0000_0000);
    tick();
    chk("rml_pc1", ifid_pc, 32'h4);
    chk("rml_instr1", ifid_instr, 32'h0050_0113);

    // Random stimulus against the reference model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                 : 32'($urandom_range(0, 320));
      load_start = ($urandom_range(0, 19) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_last = ($urandom_range(0, 11) == 0);
      load_data = $urandom;
      #1;
      exp_we = m_load && load_valid && (m_pc < 32'd256);
      chk("rnd_imem_pc", imem_pc, m_pc);
      chk("rnd_we", imem_write_en, 32'(exp_we));
      chk("rnd_ready", load_ready, 32'(m_load));
      chk("rnd_busy", busy_loading, 32'(m_load));
      tick();
      chk("rnd_valid", ifid_valid, 32'(m_v));
      chk("rnd_instr", ifid_instr, m_v ? m_instr : NOP);
      chk("rnd_ovf", load_overflow, 32'(m_ovf));
      if (m_v) begin
        chk("rnd_pc", ifid_pc, m_ipc);
        chk("rnd_pc4", ifid_pc_plus4, m_ipc + 32'd4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
